// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and parity constants
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// rtl/uart_baud_cnt.sv - bit-period counter with prescale load and bit_done pulse
module uart_baud_cnt #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      enable,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [PRESCALE_WIDTH-1:0] count;

  // prescale_q == 0 makes the terminal count all-ones: a full 2^W period
  assign bit_done = enable && (count == (prescale_q - ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
      count      <= '0;
    end else if (load) begin
      prescale_q <= prescale;
      count      <= '0;
    end else if (bit_done) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serializer with optional parity and prescaled bit timing
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_type,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state, state_next;
  logic [IDX_W-1:0]      idx, idx_next, idx_inc;
  logic                  tx_next, busy_next;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, parity_q;
  logic                  accept, bit_done;

  assign accept  = (state == ST_IDLE) && data_valid;
  assign idx_inc = idx + IDX_W'(1);

  uart_baud_cnt #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_baud_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .enable   (state != ST_IDLE),
    .prescale (prescale),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      idx    <= '0;
      tx_out <= 1'b1;
      busy   <= 1'b0;
    end else begin
      state  <= state_next;
      idx    <= idx_next;
      tx_out <= tx_next;
      busy   <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
    end else if (accept) begin
      data_q   <= p_data;
      par_en_q <= par_en;
      parity_q <= (^p_data) ^ par_type;
    end
  end

  // Next line level is decided here and registered, so tx_out never sees inputs combinationally
  always_comb begin
    state_next = state;
    idx_next   = idx;
    tx_next    = tx_out;
    busy_next  = busy;
    case (state)
      ST_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (data_valid) begin
          state_next = ST_START;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
          idx_next   = '0;
          tx_next    = data_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (idx == LAST_IDX) begin
            idx_next = '0;
            if (par_en_q) begin
              state_next = ST_PARITY;
              tx_next    = parity_q;
            end else begin
              state_next = ST_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            idx_next = idx_inc;
            tx_next  = data_q[idx_inc];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_next = ST_STOP;
          tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_next = ST_IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx against a frame-level model
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_type = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_en     (par_en),
    .par_type   (par_type),
    .prescale   (prescale),
    .tx_out     (tx_out),
    .busy       (busy)
  );

  // Called at a negedge with the DUT idle; returns at the negedge right after the frame ends
  task automatic run_frame(input logic [7:0] d, input logic pe, input logic pt,
                           input logic [5:0] ps, input bit hold, input int inject_at);
    int   period, nbits, len, ones;
    logic bits[11];
    bit   bad;
    period = (ps == 6'd0) ? 64 : int'(ps);
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = d[i];
    nbits = 9;
    if (pe) begin
      bits[9] = ((ones % 2) == 1) ? ~pt : pt;
      nbits = 10;
    end
    bits[nbits] = 1'b1;
    nbits++;
    len = nbits * period;

    p_data = d; par_en = pe; par_type = pt; prescale = ps; data_valid = 1'b1;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < len; c++) begin
      if (inject_at >= 0 && c == inject_at) begin
        data_valid = 1'b1; p_data = 8'h3C; prescale = ps + 6'd3; par_en = ~pe;
      end else if (inject_at >= 0 && c == inject_at + 1) begin
        data_valid = 1'b0;
      end
      if (!bad && (tx_out !== bits[c / period] || busy !== 1'b1)) begin
        bad = 1'b1;
        $display("FAIL frame d=%h ps=%0d cycle=%0d tx_out=%b expected=%b busy=%b expected=1",
                 d, ps, c, tx_out, bits[c / period], busy);
      end
      @(negedge clk);
    end
    checks++;
    if (bad) failures++;
    checks++;
    if (busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL frame_end d=%h busy=%b expected=0 tx_out=%b expected=1", d, busy, tx_out);
    end
  endtask

  task automatic expect_idle(input int n, input string name);
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!bad && (busy !== 1'b0 || tx_out !== 1'b1)) begin
        bad = 1'b1;
        $display("FAIL %s busy=%b expected=0 tx_out=%b expected=1", name, busy, tx_out);
      end
      @(negedge clk);
    end
    checks++;
    if (bad) failures++;
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state tx_out=%b expected=1 busy=%b expected=0", tx_out, busy);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    expect_idle(5, "idle_after_reset");
  endtask

  task automatic test_parity_frames();
    run_frame(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0, -1);
    expect_idle(4, "idle_after_even");
    run_frame(8'hA5, 1'b1, 1'b1, 6'd8, 1'b0, -1);
    expect_idle(4, "idle_after_odd");
    run_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, -1);
    expect_idle(4, "idle_after_nopar");
  endtask

  task automatic test_random();
    logic [5:0] ps_tab[6];
    ps_tab = '{6'd8, 6'd16, 6'd32, 6'd1, 6'd2, 6'd5};
    for (int i = 0; i < 8; i++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), ps_tab[$urandom_range(0, 5)], 1'b0, -1);
      expect_idle(1 + int'($urandom_range(0, 3)), "idle_random");
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ps_tab[3];
    logic       pe;
    ps_tab = '{6'd8, 6'd16, 6'd32};
    for (int g = 0; g < 3; g++) begin
      pe = 1'($urandom);
      for (int i = 0; i < 10; i++)
        run_frame(8'($urandom), pe, 1'($urandom), ps_tab[g], (i != 9), -1);
      expect_idle(3, "idle_after_burst");
    end
  endtask

  task automatic test_ignore_busy();
    run_frame(8'($urandom), 1'b1, 1'b0, 6'd8, 1'b0, 8 * 4 + 3);
    expect_idle(40, "no_second_frame");
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'($urandom);
    p_data = d; par_en = 1'b1; par_type = ^d; prescale = 6'd16; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (150) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL in_parity tx_out=%b expected=0 busy=%b expected=1", tx_out, busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset tx_out=%b expected=1 busy=%b expected=0", tx_out, busy);
    end
    @(negedge clk);
    rst = 1'b1;
    expect_idle(20, "idle_after_mid_reset");
    run_frame(8'h00, 1'b1, 1'b0, 6'd16, 1'b0, -1);
    expect_idle(4, "idle_after_zero_frame");
  endtask

  task automatic test_prescale0();
    run_frame(8'hFF, 1'b1, 1'b0, 6'd0, 1'b0, -1);
    expect_idle(4, "idle_after_ps0");
  endtask

  initial begin
    test_reset();
    test_parity_frames();
    test_random();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_prescale0();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
